// File: rtl/branch_sequencer.sv
// ---------------------------------------------------------------------------
// branch_sequencer
//
// Program-counter and control-flow stage. It sits after the status register
// and the instruction decoder. On each enabled step it picks exactly one
// next-PC source, in this priority order: return, call, jump, branch,
// sequential. Calls push PC+1 onto a small return-address stack, and returns
// pop from it. Every output is registered.
//
// Parameters:
//   ADDR_WIDTH      - program counter / target width
//   STACK_DEPTH     - number of return-address stack entries (>= 1)
//
// Ports:
//   clk_in          - clock, rising edge
//   reset_in        - asynchronous active-high reset
//   advance_in      - step enable; PC and stack only change when this is 1
//   cond_in         - registered condition bit from the status register
//   jump_en_in      - unconditional jump to target_in
//   branch_en_in    - jump to target_in when cond_in is 1
//   call_en_in      - push PC+1, then jump to target_in
//   ret_en_in       - pop the return address into the PC
//   target_in       - jump/branch/call destination
//   clear_err_in    - clears the sticky error flags on the next edge
//   pc_out          - current program counter
//   taken_out       - one-cycle pulse after a non-sequential update
//   stack_depth_out - number of valid stack entries
//   overflow_out    - sticky: a call was attempted with the stack full
//   underflow_out   - sticky: a return was attempted with the stack empty
// ---------------------------------------------------------------------------
module branch_sequencer #(
    parameter int ADDR_WIDTH  = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             clk_in,
    input  logic                             reset_in,
    input  logic                             advance_in,
    input  logic                             cond_in,
    input  logic                             jump_en_in,
    input  logic                             branch_en_in,
    input  logic                             call_en_in,
    input  logic                             ret_en_in,
    input  logic [ADDR_WIDTH-1:0]            target_in,
    input  logic                             clear_err_in,
    output logic [ADDR_WIDTH-1:0]            pc_out,
    output logic                             taken_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_depth_out,
    output logic                             overflow_out,
    output logic                             underflow_out
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] pc_q,        pc_d;
    logic                  taken_q,     taken_d;
    logic [DEPTH_W-1:0]    depth_q,     depth_d;
    logic                  overflow_q,  overflow_d;
    logic                  underflow_q, underflow_d;
    logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_WIDTH-1:0] stack_d [STACK_DEPTH];

    logic [ADDR_WIDTH-1:0] pc_plus1;
    logic                  stack_full;
    logic                  stack_empty;
    int                    push_idx;
    int                    pop_idx;

    always_comb begin
        pc_plus1    = pc_q + ADDR_WIDTH'(1);
        stack_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
        stack_empty = (depth_q == '0);
        push_idx    = int'(depth_q);
        pop_idx     = int'(depth_q) - 1;
    end

    // Next-state selection. Only the highest-priority strobe is evaluated,
    // so a lower strobe can never set an error flag. The clear is applied
    // first and a new error then overrides it, which makes set win over clear.
    always_comb begin
        pc_d        = pc_q;
        taken_d     = 1'b0;
        depth_d     = depth_q;
        overflow_d  = overflow_q  & ~clear_err_in;
        underflow_d = underflow_q & ~clear_err_in;
        stack_d     = stack_q;

        if (advance_in) begin
            if (ret_en_in) begin
                if (!stack_empty) begin
                    pc_d    = stack_q[pop_idx];
                    depth_d = depth_q - DEPTH_W'(1);
                    taken_d = 1'b1;
                end else begin
                    pc_d        = pc_plus1;
                    underflow_d = 1'b1;
                end
            end else if (call_en_in) begin
                // When the stack is full the call still transfers control.
                // Only the push is dropped, and the overflow flag records it.
                if (!stack_full) begin
                    stack_d[push_idx] = pc_plus1;
                    depth_d           = depth_q + DEPTH_W'(1);
                end else begin
                    overflow_d = 1'b1;
                end
                pc_d    = target_in;
                taken_d = 1'b1;
            end else if (jump_en_in) begin
                pc_d    = target_in;
                taken_d = 1'b1;
            end else if (branch_en_in && cond_in) begin
                pc_d    = target_in;
                taken_d = 1'b1;
            end else begin
                pc_d = pc_plus1;
            end
        end
    end

    // Control state. Reset is asynchronous so that the PC and the depth
    // clear without waiting for a clock edge.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            pc_q        <= '0;
            taken_q     <= 1'b0;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            taken_q     <= taken_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // The stack storage has no reset. Entries at or above the current depth
    // are never read, so their contents do not matter.
    always_ff @(posedge clk_in) begin
        stack_q <= stack_d;
    end

    assign pc_out          = pc_q;
    assign taken_out       = taken_q;
    assign stack_depth_out = depth_q;
    assign overflow_out    = overflow_q;
    assign underflow_out   = underflow_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_branch_sequencer
//
// Self-checking bench for branch_sequencer. It runs a linear series of
// directed scenarios, then a randomized stretch. A behavioural model predicts
// every output: the PC is an integer taken modulo 2^ADDR_WIDTH, and the
// return stack is a queue.
// ---------------------------------------------------------------------------
module tb_branch_sequencer;

    localparam int AW      = 8;
    localparam int SD      = 4;
    localparam int DW      = $clog2(SD + 1);
    localparam int PC_MOD  = 1 << AW;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic          advance_in;
    logic          cond_in;
    logic          jump_en_in;
    logic          branch_en_in;
    logic          call_en_in;
    logic          ret_en_in;
    logic [AW-1:0] target_in;
    logic          clear_err_in;
    logic [AW-1:0] pc_out;
    logic          taken_out;
    logic [DW-1:0] stack_depth_out;
    logic          overflow_out;
    logic          underflow_out;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int unsigned m_pc;
    bit          m_taken;
    int unsigned m_stack[$];
    bit          m_ovf;
    bit          m_unf;

    branch_sequencer #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD)) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .advance_in      (advance_in),
        .cond_in         (cond_in),
        .jump_en_in      (jump_en_in),
        .branch_en_in    (branch_en_in),
        .call_en_in      (call_en_in),
        .ret_en_in       (ret_en_in),
        .target_in       (target_in),
        .clear_err_in    (clear_err_in),
        .pc_out          (pc_out),
        .taken_out       (taken_out),
        .stack_depth_out (stack_depth_out),
        .overflow_out    (overflow_out),
        .underflow_out   (underflow_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic modelReset();
        m_pc    = 0;
        m_taken = 0;
        m_stack.delete();
        m_ovf   = 0;
        m_unf   = 0;
    endtask

    // Apply the rules for one clock edge to the model.
    task automatic modelStep(input bit adv, input bit cond, input bit jmp,
                             input bit br, input bit call, input bit ret,
                             input int unsigned tgt, input bit clr);
        m_taken = 0;
        if (clr) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (adv) begin
            if (ret) begin
                if (m_stack.size() > 0) begin
                    m_pc    = m_stack.pop_back();
                    m_taken = 1;
                end else begin
                    m_pc  = (m_pc + 1) % PC_MOD;
                    m_unf = 1;
                end
            end else if (call) begin
                if (m_stack.size() < SD) m_stack.push_back((m_pc + 1) % PC_MOD);
                else                     m_ovf = 1;
                m_pc    = tgt;
                m_taken = 1;
            end else if (jmp || (br && cond)) begin
                m_pc    = tgt;
                m_taken = 1;
            end else begin
                m_pc = (m_pc + 1) % PC_MOD;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [AW-1:0] exp_pc;
        logic [DW-1:0] exp_depth;
        exp_pc    = AW'(m_pc);
        exp_depth = DW'(m_stack.size());
        total++;
        assert (pc_out === exp_pc) else begin
            bad++;
            $error("[TB] FAIL %s pc: observed=%0h expected=%0h", tag, pc_out, exp_pc);
        end
        total++;
        assert (taken_out === m_taken) else begin
            bad++;
            $error("[TB] FAIL %s taken: observed=%0b expected=%0b", tag, taken_out, m_taken);
        end
        total++;
        assert (stack_depth_out === exp_depth) else begin
            bad++;
            $error("[TB] FAIL %s depth: observed=%0d expected=%0d", tag, stack_depth_out, exp_depth);
        end
        total++;
        assert (overflow_out === m_ovf) else begin
            bad++;
            $error("[TB] FAIL %s overflow: observed=%0b expected=%0b", tag, overflow_out, m_ovf);
        end
        total++;
        assert (underflow_out === m_unf) else begin
            bad++;
            $error("[TB] FAIL %s underflow: observed=%0b expected=%0b", tag, underflow_out, m_unf);
        end
    endtask

    // Drive one step at the falling edge, clock it, and check 1 ns after the edge.
    task automatic applyStimulus(input string tag, input bit adv, input bit cond,
                                 input bit jmp, input bit br, input bit call,
                                 input bit ret, input int unsigned tgt, input bit clr);
        @(negedge clk_in);
        advance_in   = adv;
        cond_in      = cond;
        jump_en_in   = jmp;
        branch_en_in = br;
        call_en_in   = call;
        ret_en_in    = ret;
        target_in    = AW'(tgt);
        clear_err_in = clr;
        modelStep(adv, cond, jmp, br, call, ret, tgt, clr);
        @(posedge clk_in);
        #1;
        checkOutput(tag);
    endtask

    // Argument order: adv, cond, jmp, br, call, ret, tgt, clr
    initial begin
        reset_in     = 1'b1;
        advance_in   = 1'b0;
        cond_in      = 1'b0;
        jump_en_in   = 1'b0;
        branch_en_in = 1'b0;
        call_en_in   = 1'b0;
        ret_en_in    = 1'b0;
        target_in    = '0;
        clear_err_in = 1'b0;
        modelReset();
        #12;
        checkOutput("reset");
        @(negedge clk_in);
        reset_in = 1'b0;

        // Sequential count and wrap: 1..255, 0, 1
        for (int i = 0; i < 257; i++) applyStimulus("seq", 1, 0, 0, 0, 0, 0, 0, 0);

        // Branch not taken, then taken, at PC 0x10
        applyStimulus("jmp10",   1, 0, 1, 0, 0, 0, 'h10, 0);
        applyStimulus("br_nt",   1, 0, 0, 1, 0, 0, 'h40, 0);
        applyStimulus("jmp10b",  1, 0, 1, 0, 0, 0, 'h10, 0);
        applyStimulus("br_t",    1, 1, 0, 1, 0, 0, 'h40, 0);
        applyStimulus("after_t", 1, 0, 0, 0, 0, 0, 0, 0);

        // Nested call and return
        applyStimulus("jmp05",  1, 0, 1, 0, 0, 0, 'h05, 0);
        applyStimulus("call20", 1, 0, 0, 0, 1, 0, 'h20, 0);
        applyStimulus("call30", 1, 0, 0, 0, 1, 0, 'h30, 0);
        applyStimulus("ret1",   1, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus("ret2",   1, 0, 0, 0, 0, 1, 0, 0);

        // Overflow, underflow and clear; set wins over a simultaneous clear
        for (int i = 0; i < 5; i++) applyStimulus("ovf_call", 1, 0, 0, 0, 1, 0, 'h80 + i * 4, 0);
        for (int i = 0; i < 5; i++) applyStimulus("unf_ret", 1, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus("clear",     0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus("set_wins",  1, 0, 0, 0, 0, 1, 0, 1);
        applyStimulus("clear2",    1, 0, 0, 0, 0, 0, 0, 1);

        // Priority: only the pop happens; a stall ignores every strobe
        applyStimulus("pcall",   1, 0, 0, 0, 1, 0, 'h60, 0);
        applyStimulus("prio",    1, 1, 1, 1, 1, 1, 'h70, 0);
        applyStimulus("pcall2",  1, 0, 0, 0, 1, 0, 'h60, 0);
        applyStimulus("stall",   0, 1, 1, 1, 1, 1, 'h70, 0);
        applyStimulus("stall2",  0, 1, 1, 1, 1, 1, 'h70, 0);

        // Asynchronous reset between edges with PC=0x33, depth=2
        applyStimulus("rcall",  1, 0, 0, 0, 1, 0, 'h50, 0);
        applyStimulus("rjmp33", 1, 0, 1, 0, 0, 0, 'h33, 0);
        @(negedge clk_in);
        advance_in = 1'b0;
        call_en_in = 1'b0;
        jump_en_in = 1'b0;
        #2;
        reset_in = 1'b1;
        modelReset();
        #1;
        checkOutput("async_rst");
        @(posedge clk_in);
        #1;
        checkOutput("rst_hold");
        @(negedge clk_in);
        reset_in = 1'b0;
        applyStimulus("post_rst", 1, 0, 0, 0, 0, 0, 0, 0);

        // Randomized stretch
        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand",
                          $urandom_range(0, 7) != 0,
                          1'($urandom_range(0, 1)),
                          $urandom_range(0, 5) == 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 4) == 0,
                          $urandom_range(0, 4) == 0,
                          $urandom_range(0, PC_MOD - 1),
                          $urandom_range(0, 15) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
